// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the multi-digit BCD up/down counter.
// Every digit register and the top-level step chain use these definitions.
package bcd_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  // Digits above 9 are forced to 9, so a bad load can never leave q holding invalid BCD.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD counter: a 4-bit register that clears, loads or steps.
// The is_max / is_min flags feed the step chain of the next digit up.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clki,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [BCD_W-1:0] load_digit,
  input  logic             step,
  input  logic             up,
  output logic [BCD_W-1:0] digit,
  output logic             is_max,
  output logic             is_min
);

  logic [BCD_W-1:0] digit_next;

  // Clear beats load, and load beats step; a digit that steps past its bound wraps within the decade.
  always_comb begin
    digit_next = digit;
    if (clr) begin
      digit_next = BCD_MIN;
    end else if (load) begin
      digit_next = bcd_clamp(load_digit);
    end else if (step) begin
      if (up) begin
        digit_next = (digit == BCD_MAX) ? BCD_MIN : digit + 4'd1;
      end else begin
        digit_next = (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
      end
    end
  end

  always_ff @(posedge clki or posedge reset) begin
    if (reset) begin
      digit <= BCD_MIN;
    end else begin
      digit <= digit_next;
    end
  end

  assign is_max = (digit == BCD_MAX);
  assign is_min = (digit == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// Parametrised multi-digit BCD up/down counter with clear, load, wrap/saturate and tc/ovf flags.
// All digits are stepped on the same edge by a combinational carry/borrow chain.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                    clki,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  input  logic                    en,
  input  logic                    up,
  output logic [BCD_W*DIGITS-1:0] q,
  output logic                    tc,
  output logic                    ovf
);

  logic [DIGITS-1:0] is_max;
  logic [DIGITS-1:0] is_min;
  logic [DIGITS-1:0] step;
  logic              at_bound;
  logic              count_go;

  assign at_bound = up ? (&is_max) : (&is_min);
  assign tc       = en & at_bound;

  // In saturate mode a count at the bound is suppressed so q holds, but ovf still reports it.
  assign count_go = en & ~(SATURATE & tc);

  always_comb begin
    step[0] = count_go;
    for (int i = 1; i < DIGITS; i++) begin
      step[i] = step[i-1] & (up ? is_max[i-1] : is_min[i-1]);
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clki       (clki),
      .reset      (reset),
      .clr        (clr),
      .load       (load),
      .load_digit (load_val[g*BCD_W +: BCD_W]),
      .step       (step[g]),
      .up         (up),
      .digit      (q[g*BCD_W +: BCD_W]),
      .is_max     (is_max[g]),
      .is_min     (is_min[g])
    );
  end

  // A count taken at the bound pulses ovf for one cycle; clr and load both suppress it.
  always_ff @(posedge clki or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else begin
      ovf <= tc & ~clr & ~load;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter: a wrap-mode and a saturate-mode instance share stimulus.
// A vector table covers carries, borrows, wrap, clamp and priority; hand sequences cover reset and saturation.
module tb_bcd_updown_counter;

  logic        clki;
  logic        reset;
  logic        clr;
  logic        load;
  logic [15:0] load_val;
  logic        en;
  logic        up;
  logic [15:0] q_w;
  logic [15:0] q_s;
  logic        tc_w;
  logic        tc_s;
  logic        ovf_w;
  logic        ovf_s;

  int check_count = 0;
  int pass_count  = 0;

  typedef struct {
    logic        clr;
    logic        load;
    logic [15:0] load_val;
    logic        en;
    logic        up;
    logic        tc_w;
    logic        tc_s;
    logic [15:0] q_w;
    logic [15:0] q_s;
    logic        ovf_w;
    logic        ovf_s;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b0)) dut_wrap (
    .clki(clki), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .q(q_w), .tc(tc_w), .ovf(ovf_w)
  );

  bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b1)) dut_sat (
    .clki(clki), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .q(q_s), .tc(tc_s), .ovf(ovf_s)
  );

  initial clki = 1'b0;
  always #5 clki = ~clki;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one vector at the falling edge, check tc before the rising edge, then q/ovf just after it.
  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clki);
    clr      = v.clr;
    load     = v.load;
    load_val = v.load_val;
    en       = v.en;
    up       = v.up;
    #1;
    checkOutput($sformatf("v%0d tc_wrap", idx), {15'd0, tc_w}, {15'd0, v.tc_w});
    checkOutput($sformatf("v%0d tc_sat", idx),  {15'd0, tc_s}, {15'd0, v.tc_s});
    @(posedge clki);
    #1;
    checkOutput($sformatf("v%0d q_wrap", idx),   q_w, v.q_w);
    checkOutput($sformatf("v%0d q_sat", idx),    q_s, v.q_s);
    checkOutput($sformatf("v%0d ovf_wrap", idx), {15'd0, ovf_w}, {15'd0, v.ovf_w});
    checkOutput($sformatf("v%0d ovf_sat", idx),  {15'd0, ovf_s}, {15'd0, v.ovf_s});
  endtask

  // Assert reset between edges, check the asynchronous clear, then release with en=1/up=1 and expect 0001.
  task automatic resetMidCycle(input string tag);
    #2;
    reset = 1'b1;
    #1;
    checkOutput({tag, " async q_wrap"},   q_w, 16'h0000);
    checkOutput({tag, " async q_sat"},    q_s, 16'h0000);
    checkOutput({tag, " async ovf_wrap"}, {15'd0, ovf_w}, 16'h0000);
    checkOutput({tag, " async ovf_sat"},  {15'd0, ovf_s}, 16'h0000);
    @(negedge clki);
    reset = 1'b0;
    clr   = 1'b0;
    load  = 1'b0;
    en    = 1'b1;
    up    = 1'b1;
    @(posedge clki);
    #1;
    checkOutput({tag, " release q_wrap"}, q_w, 16'h0001);
    checkOutput({tag, " release q_sat"},  q_s, 16'h0001);
  endtask

  initial begin
    reset    = 1'b1;
    clr      = 1'b0;
    load     = 1'b0;
    load_val = 16'h0000;
    en       = 1'b0;
    up       = 1'b1;

    //          clr   load  load_val  en    up    tc_w  tc_s  q_w       q_s       ovf_w ovf_s
    vecs[0]  = '{1'b0, 1'b1, 16'h0099, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0099, 16'h0099, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0100, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0101, 16'h0101, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 16'h0999, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0999, 16'h0999, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1000, 16'h1000, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 16'h9998, 1'b0, 1'b1, 1'b0, 1'b0, 16'h9998, 16'h9998, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h9999, 16'h9999, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h9999, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h9999, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0100, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0099, 16'h0099, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h9999, 16'h0000, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h9999, 16'h0000, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 16'h12A4, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1294, 16'h1294, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 16'h5555, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 16'h9999, 16'h9999, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 16'h9999, 1'b1, 1'b1, 1'b1, 1'b1, 16'h9999, 16'h9999, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h9999, 16'h0000, 1'b1, 1'b1};
    vecs[20] = '{1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1000, 16'h1000, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0999, 16'h0999, 1'b0, 1'b0};

    #3;
    checkOutput("reset q_wrap",   q_w, 16'h0000);
    checkOutput("reset q_sat",    q_s, 16'h0000);
    checkOutput("reset ovf_wrap", {15'd0, ovf_w}, 16'h0000);
    checkOutput("reset tc_wrap",  {15'd0, tc_w},  16'h0000);
    @(negedge clki);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Asynchronous reset while counting at 0457.
    applyStimulus('{1'b0, 1'b1, 16'h0456, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0456, 16'h0456, 1'b0, 1'b0}, 100);
    applyStimulus('{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0457, 16'h0457, 1'b0, 1'b0}, 101);
    resetMidCycle("rst0457");

    // Asynchronous reset while ovf is high must drop it at once.
    applyStimulus('{1'b0, 1'b1, 16'h9999, 1'b0, 1'b1, 1'b0, 1'b0, 16'h9999, 16'h9999, 1'b0, 1'b0}, 102);
    applyStimulus('{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h9999, 1'b1, 1'b1}, 103);
    resetMidCycle("rstovf");

    // Saturation held for three edges, then a direction flip leaves the bound with no dead cycle.
    applyStimulus('{1'b0, 1'b1, 16'h9999, 1'b0, 1'b1, 1'b0, 1'b0, 16'h9999, 16'h9999, 1'b0, 1'b0}, 200);
    applyStimulus('{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h9999, 1'b1, 1'b1}, 201);
    applyStimulus('{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0001, 16'h9999, 1'b0, 1'b1}, 202);
    applyStimulus('{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0002, 16'h9999, 1'b0, 1'b1}, 203);
    applyStimulus('{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h9998, 1'b0, 1'b0}, 204);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Parametrised multi-digit BCD counter; successor to the single-digit mod-10 synchronous counter.
- Adds:
  - configurable digit count
  - up/down direction
  - count enable
  - synchronous clear and parallel load
  - wrap or saturate mode
  - terminal-count and overflow flags
- Used for display/event counting (7-segment front ends, timers).
- Digits are cascaded by a synchronous carry/borrow chain, so all digits update on the same clki edge.

Parameters:
- DIGITS, 4: number of BCD digits; legal range 1..8.
- SATURATE, 0: 0 = wrap at bounds; 1 = hold at bounds.

Ports:
- clki  in  1  clock, rising-edge.
- reset  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous clear to zero.
- load  in  1  synchronous parallel load.
- load_val  in  4*DIGITS  BCD load value; digit 0 is in bits [3:0].
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- q  out  4*DIGITS  current BCD count; digit 0 is the least significant.
- tc  out  1  terminal count, combinational.
- ovf  out  1  registered one-cycle pulse: a bound was crossed or hit.

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clki.
- Reset values: q = 0 (all digits), ovf = 0. tc follows the tc equation with q = 0.
- Priority per clki edge: clr > load > en. With none asserted, q holds.
- clr:
  - q <= 0 next edge.
  - ovf <= 0.
- load:
  - Each digit of load_val with value >9 (0xA..0xF) is clamped to 9.
  - Other digits load unchanged.
  - ovf <= 0.
- Count, en=1, up=1:
  - Digit i increments iff all digits below i are 9. Digit 0 always steps.
  - A digit at 9 that steps goes to 0.
- Count, en=1, up=0:
  - Digit i decrements iff all digits below i are 0.
  - A digit at 0 that steps goes to 9.
- Latency: q reflects the new value on the same edge (1-cycle register). No multi-cycle ripple is allowed.
- Bounds: MAX = all digits 9; MIN = all digits 0.
- Wrap mode (SATURATE=0):
  - Up at MAX -> 0.
  - Down at MIN -> MAX.
- Saturate mode (SATURATE=1):
  - Up at MAX holds MAX.
  - Down at MIN holds MIN.
- tc = en & (up ? q==MAX : q==MIN). Purely combinational; no clr/load gating.
- ovf:
  - Set to 1 on the edge where a count is taken with tc=1 and neither clr nor load is asserted, in both modes.
  - Otherwise ovf <= 0. It is therefore exactly one cycle wide per event.
  - Continuous counting at a saturated bound pulses ovf every cycle.
- Direction change mid-count: takes effect on the next edge. No dead cycle.
- Reset mid-operation: q and ovf clear immediately (asynchronously), independent of clki.
- Invalid BCD can only enter q via load, and load clamps it, so q always holds valid BCD.
- DIGITS=1 behaves as a single decade counter with the added features.

Decomposition:
- Shared package bcd_pkg:
  - BCD_W = 4
  - BCD_MAX = 4'd9
  - BCD_MIN = 4'd0
  - function bcd_clamp (digit > 9 -> 9)
- One sub-module, bcd_digit, instantiated DIGITS times in a generate loop:
  - Inputs: clki, reset, clr, load, load_digit, step, up.
  - Output: 4-bit digit value.
  - Outputs is_max and is_min, which feed the step chain.
- Top level owns the step-enable chain (AND of lower is_max / is_min), the tc/ovf logic and the saturate gating.

Test Plan:
- Reset: assert reset mid-count at q=0x0457 between clock edges -> q=0x0000 and ovf=0 immediately, before the next clki edge. Release, en=1, up=1 -> 0x0001 after 1 edge.
- Decade carry (DIGITS=4, up=1): load 0x0099, en=1 -> next edges give 0x0100, 0x0101. Load 0x0999 -> 0x1000 in one edge.
- Up wrap, SATURATE=0: load 0x9998, count up -> 0x9999 (tc=1), then 0x0000 with ovf=1 for exactly 1 cycle.
- Down borrow/wrap: load 0x0100, up=0 -> 0x0099. Load 0x0000 -> tc=1, next edge 0x9999 with ovf pulse.
- Load clamp and priority: load_val=0x12A4 -> q=0x1294. Assert clr+load+en on the same edge with load_val=0x5555 -> q=0x0000, ovf=0.
- Saturate, SATURATE=1: at 0x9999 with en=1, up=1 for 3 edges -> q stays 0x9999 and ovf=1 each edge. Flip up=0 -> 0x9998 next edge, ovf=0.
